note_sequencer: RTL

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// Note sequencer: steps through a fixed ROM of note divider values at a
// programmable beat rate, ascending or descending, with optional looping.
// Optional build macro NOTE_SEQ_PINGPONG_EN: a looping sequence bounces back
// from its endpoint instead of wrapping to the first note.
module note_sequencer #(
    parameter int unsigned DIV_W     = 22,
    parameter int unsigned IDX_W     = 5,
    parameter int unsigned NUM_NOTES = 16,
    parameter int unsigned BEAT_W    = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic              dir,
    input  logic              loop,
    input  logic [BEAT_W-1:0] beat_len,
    output logic [DIV_W-1:0]  note_div,
    output logic [IDX_W-1:0]  note_idx,
    output logic              beat_tick,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {StIdle, StPlay, StHold} state_e;

    localparam logic [IDX_W-1:0] FirstIdx = IDX_W'(1);
    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(NUM_NOTES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIV_W-1:0]   div_q;
    logic [BEAT_W-1:0]  cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic [BEAT_W-1:0]  beat_last;
    logic               at_end;

    // Fixed note table; index 0 (rest) and anything unmapped give 1.
    function automatic logic [DIV_W-1:0] rom(input logic [IDX_W-1:0] i);
        logic [DIV_W-1:0] v;
        case (int'(i))
            1:       v = DIV_W'(227272);
            2:       v = DIV_W'(204081);
            3:       v = DIV_W'(191571);
            4:       v = DIV_W'(170648);
            5:       v = DIV_W'(151515);
            6:       v = DIV_W'(143266);
            7:       v = DIV_W'(127551);
            8:       v = DIV_W'(113636);
            9:       v = DIV_W'(101215);
            10:      v = DIV_W'(95420);
            11:      v = DIV_W'(85034);
            12:      v = DIV_W'(75758);
            13:      v = DIV_W'(71633);
            14:      v = DIV_W'(63775);
            15:      v = DIV_W'(56818);
            16:      v = DIV_W'(50607);
            default: v = DIV_W'(1);
        endcase
        return v;
    endfunction

    // Next-state logic: restart has priority over advance, end and pause.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        // beat_len of 0 behaves like 1
        beat_last = (beat_len == '0) ? '0 : beat_len - BEAT_W'(1);
        at_end    = dir_q ? (idx_q == FirstIdx) : (idx_q == LastIdx);

        if (start) begin
            state_d = StPlay;
            idx_d   = dir ? LastIdx : FirstIdx;
            cnt_d   = '0;
            dir_d   = dir;
        end else begin
            unique case (state_q)
                StIdle: begin
                    idx_d = '0;
                    cnt_d = '0;
                end
                StPlay, StHold: begin
                    if (!en) begin
                        state_d = StHold;
                    end else begin
                        // Leaving HOLD counts in the same cycle, resuming the frozen count
                        state_d = StPlay;
                        if (cnt_q >= beat_last) begin
                            cnt_d  = '0;
                            tick_d = 1'b1;
                            if (at_end) begin
                                if (loop) begin
`ifdef NOTE_SEQ_PINGPONG_EN
                                    dir_d = ~dir_q;
                                    if (NUM_NOTES == 1) begin
                                        idx_d = FirstIdx;
                                    end else begin
                                        idx_d = dir_q ? IDX_W'(2) : IDX_W'(NUM_NOTES - 1);
                                    end
`else
                                    idx_d = dir_q ? LastIdx : FirstIdx;
`endif
                                end else begin
                                    state_d = StIdle;
                                    idx_d   = '0;
                                    done_d  = 1'b1;
                                end
                            end else begin
                                idx_d = dir_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + BEAT_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers; note_div is looked up from the next index so it
    // changes on the same edge as note_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            div_q   <= DIV_W'(1);
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            div_q   <= rom(idx_d);
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign note_idx  = idx_q;
    assign note_div  = div_q;
    assign beat_tick = tick_q;
    assign done      = done_q;
    assign busy      = (state_q != StIdle);

endmodule
